// File: rtl/serial_adder_ctrl_if.sv
// Requester/decoder bundle for serial_adder_ctrl.
// slave  : controller view (takes requests, drives the decoder, returns results)
// master : environment view (requester plus the 3-to-8 decoder)
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             dec_a;
  logic             dec_b;
  logic             dec_c;
  logic [7:0]       dec_y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             err;

  modport slave (
    input  start, op_a, op_b, cin, dec_y,
    output dec_a, dec_b, dec_c, busy, done, result, cout, err
  );

  modport master (
    output start, op_a, op_b, cin, dec_y,
    input  dec_a, dec_b, dec_c, busy, done, result, cout, err
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller. Each ADD cycle the current operand
// bits and the running carry select one output of an external 3-to-8 decoder;
// sum and carry are recovered from the one-hot code and the sum bit is
// shifted into the result register LSB first.
// Optional build macro: ONEHOT_CHECK_EN -- sticky err flag when the decoder
// output is not the expected one-hot code during ADD.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  serial_adder_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_cout;

  logic             w_sum;
  logic             w_carry;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;
  logic             w_unused;

  // Decoder is driven from registers only, so dec_y settles within the cycle.
  assign bus.dec_a = r_sa[0];
  assign bus.dec_b = r_sb[0];
  assign bus.dec_c = r_carry;

  // Full-adder truth table read back out of the one-hot code:
  // odd parity minterms give the sum, majority minterms give the carry.
  assign w_sum   = bus.dec_y[1] | bus.dec_y[2] | bus.dec_y[4] | bus.dec_y[7];
  assign w_carry = bus.dec_y[3] | bus.dec_y[5] | bus.dec_y[6] | bus.dec_y[7];
  // Minterm 0 contributes to neither output.
  assign w_unused = bus.dec_y[0];

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // Result shift; a one-bit result simply takes the sum bit.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign w_res_next = w_sum;
    end else begin : g_res_wn
      assign w_res_next = {w_sum, r_result[WIDTH-1:1]};
    end
  endgenerate

  // Control FSM with datapath registers and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sa     <= '0;
      r_sb     <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cout   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_sa     <= bus.op_a;
            r_sb     <= bus.op_b;
            r_carry  <= bus.cin;
            r_cnt    <= '0;
            r_result <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_ADD;
          end
        end
        S_ADD: begin
          r_carry  <= w_carry;
          r_result <= w_res_next;
          r_sa     <= r_sa >> 1;
          r_sb     <= r_sb >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_cout  <= w_carry;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.cout   = r_cout;

`ifdef ONEHOT_CHECK_EN
  logic r_err;
  logic w_bad;

  // Zero, multiple, or wrong hot bit all indicate a broken decoder path.
  assign w_bad = !$onehot(bus.dec_y) ||
                 (bus.dec_y != (8'b1 << {r_sa[0], r_sb[0], r_carry}));

  // Sticky decoder-check flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            r_err <= 1'b0;
    else if (r_state == S_ADD && w_bad) r_err <= 1'b1;
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8). The bench models the
// 3-to-8 decoder and predicts every add as plain integer addition.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic       force_en = 1'b0;
  logic [7:0] force_val = 8'h00;

  int n_pass  = 0;
  int n_total = 0;

  serial_adder_ctrl_if #(.WIDTH(W)) bus();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Combinational 3-to-8 decoder, optionally overridden to inject faults.
  always_comb begin
    bus.dec_y = 8'b1 << {bus.dec_a, bus.dec_b, bus.dec_c};
    if (force_en) bus.dec_y = force_val;
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] exp_res;
    logic         exp_cout;
  } vec_t;

  vec_t vecs[8];

`ifdef ONEHOT_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // One complete add from IDLE, checked against integer addition.
  task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input string nm);
    logic [W:0] s;
    int n;
    s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    @(negedge clk);
    bus.start = 1'b1; bus.op_a = a; bus.op_b = b; bus.cin = c;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op_a  = W'($urandom);
    bus.op_b  = W'($urandom);
    bus.cin   = 1'($urandom);
    n = 0;
    while (bus.busy === 1'b1 && n < 4*W) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " busy_len"}, n, W);
    chk({nm, " done"}, bus.done, 1);
    chk({nm, " result"}, bus.result, s[W-1:0]);
    chk({nm, " cout"}, bus.cout, s[W]);
    chk({nm, " err"}, bus.err, 0);
    @(negedge clk);
    chk({nm, " done_clr"}, bus.done, 0);
    chk({nm, " result_hold"}, bus.result, s[W-1:0]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W:0] s;
    logic [W-1:0] ha[0:63];
    logic [W-1:0] hb[0:63];
    logic         hc[0:63];
    logic [W-1:0] got_res;
    logic         got_cout;
    int ndone, last, idx, n;

    bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.cin = 1'b0;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[4] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[7] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    chk("rst result", bus.result, 0);
    chk("rst cout", bus.cout, 0);
    chk("rst err", bus.err, 0);
    chk("rst dec", {bus.dec_a, bus.dec_b, bus.dec_c}, 0);
    rst = 1'b0;

    // Table vectors with hand-computed expectations
    for (int i = 0; i < 8; i++) begin
      s = {1'b0, vecs[i].a} + {1'b0, vecs[i].b} + {{W{1'b0}}, vecs[i].c};
      chk($sformatf("tbl%0d table_consistency", i), s, {vecs[i].exp_cout, vecs[i].exp_res});
      run_add(vecs[i].a, vecs[i].b, vecs[i].c, $sformatf("tbl%0d", i));
    end

    // Random adds against the arithmetic model
    for (int i = 0; i < 25; i++)
      run_add(W'($urandom), W'($urandom), 1'($urandom), $sformatf("rnd%0d", i));

    // start pulses while busy are ignored
    @(negedge clk);
    bus.start = 1'b1; bus.op_a = 8'h12; bus.op_b = 8'h34; bus.cin = 1'b0;
    ndone = 0; got_res = '0; got_cout = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ndone++; got_res = bus.result; got_cout = bus.cout;
      end
      if (j == 2 || j == 7) begin
        bus.start = 1'b1; bus.op_a = 8'hFF; bus.op_b = 8'hFF; bus.cin = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
    end
    chk("ignore ndone", ndone, 1);
    chk("ignore result", got_res, 8'h46);
    chk("ignore cout", got_cout, 0);

    // Reset in the middle of an add
    @(negedge clk);
    bus.start = 1'b1; bus.op_a = 8'hAA; bus.op_b = 8'h55; bus.cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst busy", bus.busy, 0);
    chk("midrst done", bus.done, 0);
    chk("midrst result", bus.result, 0);
    chk("midrst cout", bus.cout, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int j = 0; j < 2*W; j++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
    end
    chk("midrst no_done", ndone, 0);
    run_add(8'h01, 8'h01, 1'b0, "after_rst");

    // start held high: accepted only in IDLE, done every W+2 cycles
    ndone = 0; last = -1;
    for (int k = 0; k < 5*(W+2)+2; k++) begin
      @(negedge clk);
      if (k > 0 && bus.done === 1'b1) begin
        idx = k - W - 1;
        if (idx >= 0) begin
          s = {1'b0, ha[idx]} + {1'b0, hb[idx]} + {{W{1'b0}}, hc[idx]};
          chk($sformatf("b2b%0d result", ndone), {bus.cout, bus.result}, s);
        end
        if (last >= 0) chk($sformatf("b2b%0d spacing", ndone), k - last, W + 2);
        last = k;
        ndone++;
      end
      ha[k] = W'($urandom); hb[k] = W'($urandom); hc[k] = 1'($urandom);
      bus.op_a = ha[k]; bus.op_b = hb[k]; bus.cin = hc[k]; bus.start = 1'b1;
    end
    bus.start = 1'b0;
    chk("b2b ndone", ndone, 5);
    n = 0;
    while ((bus.busy === 1'b1 || bus.done === 1'b1) && n < 4*W) begin
      @(negedge clk);
      n++;
    end
    chk("b2b drain", n < 4*W, 1);

    // Decoder fault injection during ADD
    @(negedge clk);
    bus.start = 1'b1; bus.op_a = 8'h5A; bus.op_b = 8'h3C; bus.cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("err before_fault", bus.err, 0);
    force_val = 8'h03; force_en = 1'b1;
    @(negedge clk);
    force_en = 1'b0;
    chk("err after_fault", bus.err, EXP_ERR);
    n = 0;
    while (bus.done !== 1'b1 && n < 4*W) begin
      @(negedge clk);
      n++;
    end
    chk("err add_completes", bus.done, 1);
    repeat (4) @(negedge clk);
    chk("err sticky", bus.err, EXP_ERR);
    rst = 1'b1;
    #1;
    chk("err cleared_by_rst", bus.err, 0);
    @(negedge clk);
    rst = 1'b0;
    run_add(8'h0F, 8'hF0, 1'b1, "post_err");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial N-bit adder controller that drives the 3-to-8 decoder and consumes its output, forming a complete full-adder loop.
- Each cycle it presents one operand bit pair plus the registered carry to the decoder as a, b, c.
- It decodes sum and carry back out of the decoder's one-hot output.
- It shifts the sum into a result register.
- Sits between a register-file or CPU-side requester and the decoder; one add per start pulse, WIDTH cycles long.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
op_a  input  WIDTH  operand A, latched on accepted start
op_b  input  WIDTH  operand B, latched on accepted start
cin  input  1  carry-in, latched on accepted start
dec_a  output  1  to decoder a (MSB select): current A bit
dec_b  output  1  to decoder b: current B bit
dec_c  output  1  to decoder c (LSB select): current carry
dec_y  input  8  one-hot decoder output, y[i] high when {a,b,c}==i
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse, result/cout valid
result  output  WIDTH  sum, held until next accepted start
cout  output  1  final carry-out, held with result
err  output  1  sticky decoder-check flag (see Optional Feature)

Behaviour:
- Reset (async, any time including mid-add) clears the following; any in-flight add is discarded with no done:
  - state=IDLE
  - shift registers, result, carry, bit counter = 0
  - busy=0, done=0, cout=0, err=0
- States: IDLE, ADD, DONE.
- IDLE, start=1 at edge E0:
  - load sa<=op_a, sb<=op_b, carry<=cin, cnt<=0, result<=0
  - go to ADD; busy=1 from E0.
- Decoder drive: combinational from registers only.
  - dec_a=sa[0], dec_b=sb[0], dec_c=carry.
  - Decoder is combinational; dec_y is valid in the same cycle.
- ADD, each edge:
  - sum bit = dec_y[1]|dec_y[2]|dec_y[4]|dec_y[7]
  - carry <= dec_y[3]|dec_y[5]|dec_y[6]|dec_y[7]
  - result <= {sum, result[WIDTH-1:1]} (LSB first, so the final bit lands in MSB)
  - sa, sb shift right with 0 fill; cnt <= cnt+1
- Edge where cnt==WIDTH-1: last bit processed; go to DONE.
  - Outputs after that edge (edge E_WIDTH): busy=0, done=1, cout=final carry.
- DONE: next edge returns to IDLE, done=0; result/cout hold.
- Latency: done is high in the cycle after edge E_WIDTH, i.e. WIDTH+1 cycles after start is sampled. Throughput is one add per WIDTH+2 cycles minimum.
- start is ignored in ADD and DONE; no queuing.
- op_a/op_b/cin changes after acceptance have no effect.
- WIDTH=1: exactly one ADD cycle.
- Counter width: $clog2(WIDTH)+1 bits; no wrap.

Optional Feature:
Macro ONEHOT_CHECK_EN.
- Defined:
  - In ADD, if dec_y is not exactly one-hot (zero or more than one bit set) → err<=1, sticky until rst.
  - Additionally, if dec_y != (8'b1 << {dec_a,dec_b,dec_c}), err<=1 (mismatch check).
  - Arithmetic is unaffected; the add completes normally.
- Undefined: err tied 0, no check logic synthesized.

Test Plan:
- WIDTH=8, op_a=8'h5A, op_b=8'h3C, cin=0, start → busy for 8 cycles, done pulse at cycle 9, result=8'h96, cout=0.
- op_a=8'hFF, op_b=8'h01, cin=0 → result=8'h00, cout=1; op_a=8'hFF, op_b=8'hFF, cin=1 → result=8'hFF, cout=1.
- Start 8'h12+8'h34, pulse start again with 8'hFF+8'hFF at cycles 3 and 8 (busy) → second ignored; result=8'h46, cout=0, exactly one done.
- Start 8'hAA+8'h55, assert rst at cycle 4 → all outputs 0 immediately, no done; new start 8'h01+8'h01 after release → result=8'h02.
- Back-to-back: start held high continuously → adds accepted only in IDLE, done every WIDTH+2 cycles, result correct each time.
- ONEHOT_CHECK_EN defined: force dec_y=8'h03 for one ADD cycle → err=1 and stays 1 until rst; undefined build → err stays 0.
